ex_stage_fwd: RTL and testbench
===============================

# ex_stage_fwd

Parametrised DLX execute stage with built-in operand forwarding, load-use bubble insertion, branch-condition resolution, an iterative multi-cycle multiplier and an EX/MEM pipeline register with stall and flush. It sits between the ID/EX register and the MEM stage. It replaces the fixed 32-bit, free-running execute stage with one that honours a ready/valid handshake and can hold or squash its contents.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8; shift amount uses the low log2(WIDTH) bits of B
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ID/EX holds an instruction
- in_ready  out  1  instruction accepted at this edge when in_valid & in_ready
- in_a, in_b, in_imm  in  WIDTH  register operands; sign-extended immediate
- in_alusrc  in  1  1: ALU B = in_imm (rt not a source)
- in_rs, in_rt, in_rd  in  RA_W  source and destination addresses
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; others pass B
- in_br_type  in  2  0 none, 1 BEQZ, 2 BNEZ, 3 BGTZ (signed)
- in_regwrite, in_memtoreg, in_memwrite  in  1  control passed to MEM
- wb_regwrite  in  1  writeback-bus write enable
- wb_rd  in  RA_W  writeback-bus address
- wb_data  in  WIDTH  writeback-bus data
- stall_in  in  1  MEM not ready; EX/MEM register holds
- flush  in  1  squash EX contents
- ex_valid  out  1  EX/MEM register holds a live instruction
- ex_result, ex_store_data  out  WIDTH  ALU or product result; forwarded B for stores
- ex_rd  out  RA_W  destination address
- ex_regwrite, ex_memtoreg, ex_memwrite  out  1  registered control
- ex_carry, ex_overflow, ex_zero  out  1  registered flags
- ex_br_taken  out  1  branch condition true, qualified by ex_valid

## Operation
**Forwarding** (per source: rs; rt only when in_alusrc=0 or in_memwrite=1)
- EX match wins: ex_valid & ex_regwrite & ~ex_memtoreg & ex_rd==src & src!=0 -> ex_result.
- Otherwise WB match: wb_regwrite & wb_rd==src & src!=0 -> wb_data.
- Otherwise the register-file value.

**Load-use**
- Hazard: in_valid & ex_valid & ex_memtoreg & ex_regwrite & ex_rd!=0 & a used source equals ex_rd.
- Response: in_ready=0 and a bubble is written into EX/MEM (ex_valid<=0).
- wb_* presents the load data on the cycle after the load leaves ex_*.

**Arithmetic**
- ADD/SUB are modulo 2^WIDTH.
- ex_carry: carry-out for ADD; A>=B unsigned for SUB; 0 for all other ops.
- ex_overflow: signed overflow for ADD/SUB; 0 for all other ops.
- SLT/SLTU return 0 or 1.
- ex_zero: result==0.
- Branch evaluation uses forwarded A. BGTZ is true when A[WIDTH-1]==0 and A!=0.

**FSM**
- IDLE:
  - ALU op accepted -> EX/MEM loaded, stay IDLE.
  - MUL accepted -> MUL; latch operands, count = WIDTH.
- MUL:
  - One shift-add step per cycle; result is the low WIDTH bits of the product.
  - When count reaches 0 and ~stall_in: write product, ex_valid=1, carry=overflow=0, next IDLE.
  - When count reaches 0 and stall_in=1: hold, retrying each cycle.
- in_ready = ~reset & state==IDLE & ~stall_in & ~hazard & ~flush.
- While in MUL, EX/MEM emits bubbles (ex_valid=0) whenever ~stall_in.

**Flush** (highest priority)
- ex_valid<=0.
- An instruction presented this cycle is not accepted.
- MUL is aborted, next state IDLE.

**Stall**
- stall_in=1 and flush=0: all ex_* hold their values; nothing is accepted.

## Timing
- Reset (async) drives these to 0: every ex_* output, state IDLE, count 0. in_ready is 0 while reset is high.
- ALU op accepted at edge N: ex_* valid after edge N, i.e. latency 1.
- MUL accepted at edge N: ex_valid=0 for edges N+1..N+WIDTH-1; product appears after edge N+WIDTH when not stalled.
  - Each stalled cycle at completion adds 1 cycle of latency.
- Load-use: one bubble edge, then the dependent instruction is accepted at the next edge with WB forwarding.
- Simultaneous flush and stall_in: flush wins.
- Simultaneous EX and WB match: EX wins.
- Source address 0: never forwarded; always reads as the input value.
- Reset asserted mid-MUL: immediate IDLE, no output produced.

## Test plan
- **ALU ops:** ADD 0x7FFFFFFF+1 -> ex_result 0x80000000, overflow=1, carry=0. SUB 5-5 -> zero=1, carry=1. SRA 0x80000000 by 4 -> 0xF8000000.
- **Forwarding priority:** ADD r3=2+3, then SUB r4=r3-1 with wb_rd=3, wb_data=99 -> ex_result 4, because the EX match wins over the WB match.
- **Load-use:** LW r5 followed by ADD r6=r5+r5 with wb_data=7 for r5 -> one bubble (in_ready=0 for one cycle), then ex_result 14.
- **Multiply:** MUL 0x0000FFFF*0x00010001 -> in_ready low for 32 cycles, ex_result 0xFFFFFFFF. Hold stall_in at completion for 3 cycles -> product appears 3 cycles later.
- **Branch:** BGTZ with A=0 -> ex_br_taken=0; A=1 -> 1; A=0x80000000 -> 0. BNEZ with a forwarded EX result 0 -> 0.
- **Flush and reset mid-multiply:** flush at cycle 10 of a MUL -> ex_valid stays 0, in_ready=1 next cycle. Async reset mid-MUL -> every ex_* output is 0 immediately, state IDLE.

Source files
------------

// File: rtl/ex_stage_fwd.sv
// DLX execute stage: operand forwarding, load-use bubbles, branch resolution,
// an iterative shift-add multiplier and an EX/MEM register with stall and flush.
module ex_stage_fwd #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              in_alusrc,
  input  logic [RA_W-1:0]   in_rs,
  input  logic [RA_W-1:0]   in_rt,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [3:0]        in_op,
  input  logic [1:0]        in_br_type,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic              in_memwrite,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              stall_in,
  input  logic              flush,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_result,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_carry,
  output logic              ex_overflow,
  output logic              ex_zero,
  output logic              ex_br_taken
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mul_a, mul_b, acc, acc_next, product;
  logic [RA_W-1:0]    m_rd;
  logic               m_regwrite, m_memtoreg, m_memwrite, m_br;
  logic [WIDTH-1:0]   m_store;
  logic               br_q;

  logic               use_rt, ex_fwd_ok, hazard, accept, is_mul;
  logic [WIDTH-1:0]   fwd_a, fwd_b, alu_b, alu_res;
  logic               alu_c, alu_v, br_cond;
  logic [SH_W-1:0]    sh;
  logic               load_alu, start_mul, mul_step, write_prod, bubble, mul_done;

  // EX result beats the writeback bus; address 0 is hard-wired and never forwarded.
  function automatic logic [WIDTH-1:0] forward(
    input logic [RA_W-1:0]  src,
    input logic [WIDTH-1:0] rf_val,
    input logic             ex_ok,
    input logic [RA_W-1:0]  ex_dst,
    input logic [WIDTH-1:0] ex_val,
    input logic             wb_ok,
    input logic [RA_W-1:0]  wb_dst,
    input logic [WIDTH-1:0] wb_val
  );
    if (src != '0 && ex_ok && ex_dst == src)      return ex_val;
    else if (src != '0 && wb_ok && wb_dst == src) return wb_val;
    else                                          return rf_val;
  endfunction

  assign use_rt    = ~in_alusrc | in_memwrite;
  assign ex_fwd_ok = ex_valid & ex_regwrite & ~ex_memtoreg;
  assign fwd_a     = forward(in_rs, in_a, ex_fwd_ok, ex_rd, ex_result,
                             wb_regwrite, wb_rd, wb_data);
  assign fwd_b     = use_rt ? forward(in_rt, in_b, ex_fwd_ok, ex_rd, ex_result,
                                      wb_regwrite, wb_rd, wb_data)
                            : in_b;
  assign alu_b     = in_alusrc ? in_imm : fwd_b;
  assign sh        = alu_b[SH_W-1:0];

  assign hazard = in_valid & ex_valid & ex_memtoreg & ex_regwrite & (ex_rd != '0) &
                  ((in_rs == ex_rd) | (use_rt & (in_rt == ex_rd)));

  assign in_ready = ~reset & (state == S_IDLE) & ~stall_in & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;
  assign is_mul   = (in_op == OP_MUL);

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (in_op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, fwd_a} + {1'b0, alu_b};
        alu_v = (fwd_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != fwd_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = fwd_a - alu_b;
        alu_c   = (fwd_a >= alu_b);
        alu_v   = (fwd_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != fwd_a[WIDTH-1]);
      end
      OP_AND:  alu_res = fwd_a & alu_b;
      OP_OR:   alu_res = fwd_a | alu_b;
      OP_XOR:  alu_res = fwd_a ^ alu_b;
      OP_SLL:  alu_res = fwd_a << sh;
      OP_SRL:  alu_res = fwd_a >> sh;
      OP_SRA:  alu_res = $signed(fwd_a) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (fwd_a < alu_b)};
      default: alu_res = alu_b;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (in_br_type)
      2'd1:    br_cond = (fwd_a == '0);
      2'd2:    br_cond = (fwd_a != '0);
      2'd3:    br_cond = ~fwd_a[WIDTH-1] && (fwd_a != '0);
      default: br_cond = 1'b0;
    endcase
  end

  // The final shift-add step and the write-back share an edge, so a product is
  // available either from this step (count==1) or from the accumulator (count==0).
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);
  assign mul_done = (state == S_MUL) && (count <= CNT_W'(1));
  assign product  = (count == '0) ? acc : acc_next;

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    start_mul  = 1'b0;
    mul_step   = 1'b0;
    write_prod = 1'b0;
    bubble     = 1'b0;
    if (flush) begin
      state_next = S_IDLE;
      bubble     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (!stall_in) begin
            if (accept && is_mul) begin
              start_mul  = 1'b1;
              bubble     = 1'b1;
              state_next = S_MUL;
            end else if (accept) begin
              load_alu = 1'b1;
            end else begin
              bubble = 1'b1;
            end
          end
        end
        S_MUL: begin
          mul_step = (count != '0);
          if (mul_done && !stall_in) begin
            write_prod = 1'b1;
            state_next = S_IDLE;
          end else if (!stall_in) begin
            bubble = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      acc        <= '0;
      m_rd       <= '0;
      m_regwrite <= 1'b0;
      m_memtoreg <= 1'b0;
      m_memwrite <= 1'b0;
      m_br       <= 1'b0;
      m_store    <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (start_mul) begin
      count      <= CNT_W'(WIDTH);
      mul_a      <= fwd_a;
      mul_b      <= alu_b;
      acc        <= '0;
      m_rd       <= in_rd;
      m_regwrite <= in_regwrite;
      m_memtoreg <= in_memtoreg;
      m_memwrite <= in_memwrite;
      m_br       <= br_cond;
      m_store    <= fwd_b;
    end else if (mul_step) begin
      count <= count - CNT_W'(1);
      acc   <= acc_next;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_carry      <= 1'b0;
      ex_overflow   <= 1'b0;
      ex_zero       <= 1'b0;
      br_q          <= 1'b0;
    end else if (load_alu) begin
      ex_valid      <= 1'b1;
      ex_result     <= alu_res;
      ex_store_data <= fwd_b;
      ex_rd         <= in_rd;
      ex_regwrite   <= in_regwrite;
      ex_memtoreg   <= in_memtoreg;
      ex_memwrite   <= in_memwrite;
      ex_carry      <= alu_c;
      ex_overflow   <= alu_v;
      ex_zero       <= (alu_res == '0);
      br_q          <= br_cond;
    end else if (write_prod) begin
      ex_valid      <= 1'b1;
      ex_result     <= product;
      ex_store_data <= m_store;
      ex_rd         <= m_rd;
      ex_regwrite   <= m_regwrite;
      ex_memtoreg   <= m_memtoreg;
      ex_memwrite   <= m_memwrite;
      ex_carry      <= 1'b0;
      ex_overflow   <= 1'b0;
      ex_zero       <= (product == '0);
      br_q          <= m_br;
    end else if (bubble) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_br_taken = ex_valid & br_q;

endmodule

// File: tb/tb_ex_stage_fwd.sv
// Self-checking bench for ex_stage_fwd: directed scenarios plus a randomized
// ALU/forwarding run against a behavioural model of the execute stage.
module tb_ex_stage_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b, in_imm;
  logic        in_alusrc;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [3:0]  in_op;
  logic [1:0]  in_br_type;
  logic        in_regwrite, in_memtoreg, in_memwrite;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_in, flush;
  logic        ex_valid;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memtoreg, ex_memwrite;
  logic        ex_carry, ex_overflow, ex_zero, ex_br_taken;

  int checks = 0;
  int errors = 0;

  logic [76:0] ex_vec;
  assign ex_vec = {ex_valid, ex_result, ex_store_data, ex_rd, ex_regwrite, ex_memtoreg,
                   ex_memwrite, ex_carry, ex_overflow, ex_zero, ex_br_taken};

  always #5 clk = ~clk;

  ex_stage_fwd #(.WIDTH(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op), .in_br_type(in_br_type),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_memwrite(in_memwrite),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_carry(ex_carry), .ex_overflow(ex_overflow), .ex_zero(ex_zero),
    .ex_br_taken(ex_br_taken)
  );

  // Reference arithmetic done in 64-bit signed/unsigned integers.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    int sh = int'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = sa + sb; r = 32'(ua + ub);
        c = (ua + ub) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s = sa - sb; r = 32'(ua - ub);
        c = (ua >= ub);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = 32'(ua << sh);
      4'd6:  r = 32'(ua >> sh);
      4'd7:  r = 32'(sa >>> sh);
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: r = 32'(ua * ub);
      default: r = b;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [1:0] bt, input logic [31:0] a);
    case (bt)
      2'd1:    return a == 0;
      2'd2:    return a != 0;
      2'd3:    return $signed(a) > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_a = 0; in_b = 0; in_imm = 0; in_alusrc = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_op = 0; in_br_type = 0;
    in_regwrite = 0; in_memtoreg = 0; in_memwrite = 0;
    wb_regwrite = 0; wb_rd = 0; wb_data = 0; stall_in = 0; flush = 0;
  endtask

  task automatic drive_instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic alusrc, input logic rw,
                             input logic mtr, input logic mw, input logic [1:0] bt);
    in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_a = a; in_b = b; in_imm = imm; in_alusrc = alusrc;
    in_regwrite = rw; in_memtoreg = mtr; in_memwrite = mw; in_br_type = bt;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    step(); step();
    checks++;
    if (ex_vec !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ex=%h ready=%b, required ex=0 ready=0", ex_vec, in_ready);
    end
    reset = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
    step();
  endtask

  task automatic test_alu_directed();
    drive_instr(4'd0, 5'd1, 5'd2, 5'd8, 32'h7FFF_FFFF, 32'd1, 0, 0, 1, 0, 0, 0);
    step();
    checks++;
    if ({ex_valid, ex_result, ex_carry, ex_overflow, ex_zero} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_overflow: v=%b r=%h c=%b o=%b z=%b, required 1 80000000 0 1 0",
               ex_valid, ex_result, ex_carry, ex_overflow, ex_zero);
    end
    drive_instr(4'd1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd5, 0, 0, 1, 0, 0, 0);
    step();
    checks++;
    if ({ex_result, ex_carry, ex_overflow, ex_zero} !== {32'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_zero: r=%h c=%b o=%b z=%b, required 0 1 0 1",
               ex_result, ex_carry, ex_overflow, ex_zero);
    end
    drive_instr(4'd7, 5'd1, 5'd2, 5'd10, 32'h8000_0000, 32'd4, 0, 0, 1, 0, 0, 0);
    step();
    checks++;
    if ({ex_result, ex_carry, ex_overflow} !== {32'hF800_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sra: r=%h c=%b o=%b, required f8000000 0 0", ex_result, ex_carry, ex_overflow);
    end
    drive_idle();
    step();
  endtask

  task automatic test_forwarding();
    // ADD r3 = 2 + 3
    drive_instr(4'd0, 5'd1, 5'd2, 5'd3, 32'd2, 32'd3, 0, 0, 1, 0, 0, 0);
    step();
    // SUB r4 = r3 - 1 with WB also offering r3 = 99
    drive_instr(4'd1, 5'd3, 5'd0, 5'd4, 32'd50, 32'd0, 32'd1, 1, 1, 0, 0, 0);
    wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'd99;
    step();
    checks++;
    if (ex_result !== 32'd4) begin
      errors++;
      $display("FAIL fwd_ex_priority: got %0d, required 4", ex_result);
    end
    // EX now holds r4; r3 must come from the WB bus
    drive_instr(4'd0, 5'd3, 5'd0, 5'd5, 32'd50, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    step();
    checks++;
    if (ex_result !== 32'd99) begin
      errors++;
      $display("FAIL fwd_wb: got %0d, required 99", ex_result);
    end
    // Writing r0 must never forward
    drive_instr(4'd0, 5'd0, 5'd0, 5'd0, 32'd77, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    wb_regwrite = 1; wb_rd = 5'd0; wb_data = 32'd1;
    step();
    drive_instr(4'd0, 5'd0, 5'd0, 5'd6, 32'd5, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    step();
    checks++;
    if (ex_result !== 32'd5) begin
      errors++;
      $display("FAIL fwd_r0: got %0d, required 5", ex_result);
    end
    drive_idle();
    step();
  endtask

  task automatic test_load_use();
    drive_instr(4'd0, 5'd0, 5'd0, 5'd5, 32'd100, 32'd0, 32'd0, 1, 1, 1, 0, 0);
    step();
    drive_instr(4'd0, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_stall: ready=%b, required 0", in_ready);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_bubble: ex_valid=%b, required 0", ex_valid);
    end
    wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'd7;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL loaduse_release: ready=%b, required 1", in_ready);
    end
    step();
    checks++;
    if ({ex_valid, ex_result, ex_rd} !== {1'b1, 32'd14, 5'd6}) begin
      errors++;
      $display("FAIL loaduse_result: v=%b r=%0d rd=%0d, required 1 14 6", ex_valid, ex_result, ex_rd);
    end
    drive_idle();
    step();
  endtask

  task automatic test_multiply();
    int lows = 0;
    int cycles = 0;
    int early = 0;
    logic [31:0] a, b, r;
    logic c, v;
    drive_instr(4'd10, 5'd0, 5'd0, 5'd7, 32'h0000_FFFF, 32'h0001_0001, 0, 0, 1, 0, 0, 0);
    step();
    drive_idle();
    while (!ex_valid && cycles < 100) begin
      if (!in_ready) lows++;
      step();
      cycles++;
    end
    checks++;
    if (lows != 32 || cycles != 32) begin
      errors++;
      $display("FAIL mul_latency: ready low %0d cycles, done after %0d, required 32 32", lows, cycles);
    end
    checks++;
    if ({ex_valid, ex_result, ex_rd, ex_carry, ex_overflow} !== {1'b1, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_result: v=%b r=%h rd=%0d c=%b o=%b, required 1 ffffffff 7 0 0",
               ex_valid, ex_result, ex_rd, ex_carry, ex_overflow);
    end
    // Stall held across completion for three edges
    a = $urandom; b = $urandom;
    ref_alu(4'd10, a, b, r, c, v);
    drive_instr(4'd10, 5'd0, 5'd0, 5'd13, a, b, 0, 0, 1, 0, 0, 0);
    step();
    drive_idle();
    for (int i = 0; i < 31; i++) begin
      step();
      if (ex_valid) early++;
    end
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ex_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL mul_stall_early: ex_valid seen %0d times, required 0", early);
    end
    stall_in = 0;
    step();
    checks++;
    if ({ex_valid, ex_result, ex_rd} !== {1'b1, r, 5'd13}) begin
      errors++;
      $display("FAIL mul_stall_result: v=%b r=%h rd=%0d, required 1 %h 13", ex_valid, ex_result, ex_rd, r);
    end
    drive_idle();
    step();
  endtask

  task automatic test_branch();
    logic [31:0] vals [3] = '{32'd0, 32'd1, 32'h8000_0000};
    logic        exp [3]  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_instr(4'd0, 5'd1, 5'd0, 5'd0, vals[i], 32'd0, 32'd0, 1, 0, 0, 0, 2'd3);
      step();
      checks++;
      if ({ex_valid, ex_br_taken} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL bgtz_%0d: v=%b taken=%b, required 1 %b", i, ex_valid, ex_br_taken, exp[i]);
      end
    end
    drive_instr(4'd0, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, 0, 1, 0, 0, 0);
    step();
    drive_instr(4'd0, 5'd2, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 1, 0, 0, 0, 2'd2);
    step();
    checks++;
    if ({ex_valid, ex_br_taken} !== 2'b10) begin
      errors++;
      $display("FAIL bnez_fwd: v=%b taken=%b, required 1 0", ex_valid, ex_br_taken);
    end
    drive_idle();
    step();
  endtask

  task automatic test_stall_flush();
    drive_instr(4'd0, 5'd0, 5'd0, 5'd12, 32'd10, 32'd20, 0, 0, 1, 0, 0, 0);
    step();
    drive_instr(4'd1, 5'd0, 5'd0, 5'd14, 32'd1, 32'd1, 0, 0, 1, 0, 0, 0);
    stall_in = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready: ready=%b, required 0", in_ready);
    end
    step(); step();
    checks++;
    if ({ex_valid, ex_result, ex_rd} !== {1'b1, 32'd30, 5'd12}) begin
      errors++;
      $display("FAIL stall_hold: v=%b r=%0d rd=%0d, required 1 30 12", ex_valid, ex_result, ex_rd);
    end
    flush = 1;
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall: ex_valid=%b, required 0", ex_valid);
    end
    drive_idle();
    step();
  endtask

  task automatic test_flush_mul();
    int seen = 0;
    drive_instr(4'd10, 5'd0, 5'd0, 5'd7, 32'd3, 32'd5, 0, 0, 1, 0, 0, 0);
    step();
    drive_idle();
    for (int i = 0; i < 9; i++) step();
    flush = 1;
    drive_instr(4'd0, 5'd0, 5'd0, 5'd9, 32'd1, 32'd1, 0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: ready=%b, required 0", in_ready);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if ({ex_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_mul: v=%b ready=%b, required 0 1", ex_valid, in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_mul_no_product: ex_valid seen %0d times, required 0", seen);
    end
  endtask

  task automatic test_reset_mul();
    int seen = 0;
    drive_instr(4'd0, 5'd0, 5'd0, 5'd11, 32'd3, 32'd4, 0, 0, 1, 0, 1, 2'd2);
    step();
    drive_instr(4'd10, 5'd0, 5'd0, 5'd7, 32'd6, 32'd7, 0, 0, 1, 0, 0, 0);
    step();
    drive_idle();
    for (int i = 0; i < 5; i++) step();
    #1 reset = 1;
    #1;
    checks++;
    if (ex_vec !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: ex=%h ready=%b, required ex=0 ready=0", ex_vec, in_ready);
    end
    #1 reset = 0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mul_idle: ready=%b, required 1", in_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mul_no_product: ex_valid seen %0d times, required 0", seen);
    end
  endtask

  task automatic test_random();
    logic        m_live = 0, m_rw = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_res = 0;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, fa, fb, opb, r;
    logic        v, alusrc, rw, mw, c, o, br;
    logic [1:0]  bt;
    logic [76:0] exp_vec;
    drive_idle();
    step();
    for (int it = 0; it < 300; it++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd10) op = 4'd0;
      v = ($urandom_range(0, 7) != 0);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      a = $urandom; b = $urandom; imm = $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 2));
      alusrc = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1)); bt = 2'($urandom_range(0, 3));
      drive_instr(op, rs, rt, rd, a, b, imm, alusrc, rw, 0, mw, bt);
      in_valid = v;
      wb_regwrite = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;

      if (rs != 0 && m_live && m_rw && m_rd == rs)        fa = m_res;
      else if (rs != 0 && wb_regwrite && wb_rd == rs)     fa = wb_data;
      else                                                fa = a;
      if (alusrc && !mw)                                  fb = b;
      else if (rt != 0 && m_live && m_rw && m_rd == rt)   fb = m_res;
      else if (rt != 0 && wb_regwrite && wb_rd == rt)     fb = wb_data;
      else                                                fb = b;
      opb = alusrc ? imm : fb;
      ref_alu(op, fa, opb, r, c, o);
      br = ref_branch(bt, fa);
      exp_vec = {1'b1, r, fb, rd, rw, 1'b0, mw, c, o, (r == 0), br};

      step();
      checks++;
      if (v) begin
        if (ex_vec !== exp_vec) begin
          errors++;
          $display("FAIL random_%0d op=%0d: got %h, required %h", it, op, ex_vec, exp_vec);
        end
        m_live = 1; m_rw = rw; m_rd = rd; m_res = r;
      end else begin
        if ({ex_valid, ex_br_taken} !== 2'b00) begin
          errors++;
          $display("FAIL random_bubble_%0d: v=%b taken=%b, required 0 0", it, ex_valid, ex_br_taken);
        end
        m_live = 0;
      end
    end
    drive_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_forwarding();
    test_load_use();
    test_multiply();
    test_branch();
    test_stall_flush();
    test_flush_mul();
    test_reset_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
